vedic_stream_ctrl: RTL and testbench

- Sequential front/back end for the combinational 16x16 vedic multiplier.
- Collects two 16-bit operands as four bytes over an 8-bit valid/ready stream and drives them as registered operands into the multiplier.
- Captures the 32-bit product and streams it out as four bytes over an 8-bit valid/ready stream.
- Sits between the chip's byte-wide pins and the multiplier instance.

---
 rtl/vedic_pkg.sv | 27 ++
 rtl/vedic_stream_ctrl.sv | 140 ++++++++++++++
 tb/tb_vedic_stream_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vedic_pkg.sv
// Shared types and widths for the vedic multiplier stream controller.
// Contents: the FSM state enum, the operand/result/byte widths, and a
// helper that picks one byte out of the result word.
package vedic_pkg;

  localparam int unsigned OP_W       = 16;
  localparam int unsigned RES_W      = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NBYTES_IN  = 4;
  localparam int unsigned NBYTES_OUT = 4;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  // Little-endian byte select: idx 0 -> r[7:0]
  function automatic logic [BYTE_W-1:0] res_byte(input logic [RES_W-1:0] r,
                                                 input logic [CNT_W-1:0] idx);
    logic [4:0] sh;
    sh = {idx, 3'b000};
    return BYTE_W'(r >> sh);
  endfunction

endpackage

// File: rtl/vedic_stream_ctrl.sv
// Byte-stream front/back end for the combinational 16x16 vedic multiplier.
// Collects four input bytes (A lo, A hi, B lo, B hi), holds them as registered
// operands for one CALC cycle, captures the 32-bit product and returns it as
// four little-endian bytes.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_data/in_ready    upstream byte stream
//   mul_a, mul_b          registered operands to the external multiplier
//   mul_r                 product from the multiplier (combinational)
//   acc_clr               accumulator clear (only with VEDIC_ACC_EN)
//   out_valid/out_data/out_ready downstream byte stream
//   busy                  high in CALC or SEND
// Build option: define VEDIC_ACC_EN to add a wrapping 32-bit accumulator;
// without it acc_clr is ignored.
module vedic_stream_ctrl
  import vedic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [RES_W-1:0]  mul_r,
  input  logic              acc_clr,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [OP_W-1:0]   r_mul_a;
  logic [OP_W-1:0]   r_mul_b;
  logic [RES_W-1:0]  r_res;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [BYTE_W-1:0] r_out_data;
  logic              r_busy;
  logic [RES_W-1:0]  w_calc;

`ifdef VEDIC_ACC_EN
  logic [RES_W-1:0] r_acc;

  // Clear-then-add when acc_clr is seen in CALC; sum wraps mod 2^32
  assign w_calc = acc_clr ? mul_r : RES_W'(r_acc + mul_r);

  // Accumulator: loads in CALC, clears on acc_clr elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_calc;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end
`else
  logic w_unused_acc_clr;

  assign w_calc           = mul_r;
  assign w_unused_acc_clr = acc_clr;
`endif

  // Control FSM with registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid && r_in_ready) begin
            case (r_cnt)
              2'd0:    r_mul_a[7:0]  <= in_data;
              2'd1:    r_mul_a[15:8] <= in_data;
              2'd2:    r_mul_b[7:0]  <= in_data;
              default: r_mul_b[15:8] <= in_data;
            endcase
            if (r_cnt == 2'd3) begin
              r_cnt      <= '0;
              r_state    <= CALC;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        CALC: begin
          // Byte 0 is presented straight from the value being captured
          r_res       <= w_calc;
          r_out_data  <= res_byte(w_calc, 2'd0);
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= SEND;
        end
        SEND: begin
          if (r_out_valid && out_ready) begin
            if (r_cnt == 2'd3) begin
              r_cnt       <= '0;
              r_state     <= LOAD;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_cnt      <= r_cnt + 2'd1;
              r_out_data <= res_byte(r_res, r_cnt + 2'd1);
            end
          end
        end
        default: begin
          r_state     <= LOAD;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_vedic_stream_ctrl.sv
// Scoreboard bench for vedic_stream_ctrl: stimulus pushes expected output
// bytes into a queue, a negedge monitor pops and compares on each transfer.
module tb_vedic_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_r;
  logic        acc_clr;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

`ifdef VEDIC_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  always #5 clk = ~clk;

  // External multiplier stand-in
  assign mul_r = {16'h0, mul_a} * {16'h0, mul_b};

  vedic_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
    .acc_clr(acc_clr),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (bound expired or unexpected event)", name);
  endtask

  // Monitor: a transfer happens at the next posedge when valid & ready now
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_byte");
        else check("out_byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) fail_now("in_ready_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check("busy_low_in_gap", {31'h0, busy}, 32'd0);
    end
  endtask

  // Four-byte load; checks the CALC cycle and one-cycle output latency
  task automatic load(input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] p, input int gap, input string tag);
    exp_q.push_back(p[7:0]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[23:16]);
    exp_q.push_back(p[31:24]);
    send_byte(a[7:0], gap);
    send_byte(a[15:8], gap);
    send_byte(b[7:0], gap);
    send_byte(b[15:8], 0);
    check({tag, "_calc_out_valid"}, {31'h0, out_valid}, 32'd0);
    check({tag, "_calc_busy"}, {31'h0, busy}, 32'd1);
    check({tag, "_calc_in_ready"}, {31'h0, in_ready}, 32'd0);
    check({tag, "_mul_a"}, {16'h0, mul_a}, {16'h0, a});
    check({tag, "_mul_b"}, {16'h0, mul_b}, {16'h0, b});
    @(posedge clk); #1;
    check({tag, "_send_out_valid"}, {31'h0, out_valid}, 32'd1);
    check({tag, "_send_busy"}, {31'h0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now({tag, "_done_timeout"});
    check({tag, "_idle_busy"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    acc_clr   = ACC;
    #12;
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_out_data", {24'h0, out_data}, 32'd0);
    check("rst_mul_a", {16'h0, mul_a}, 32'd0);
    check("rst_mul_b", {16'h0, mul_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    load(16'h1234, 16'h5678, 32'h0626_0060, 0, "t1");
    wait_done("t1");
    load(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, "t2");
    wait_done("t2");
    load(16'h0000, 16'hABCD, 32'h0000_0000, 0, "t3");
    wait_done("t3");

    // Backpressure on byte 1, with ignored in_valid pulses
    load(16'h1111, 16'h0011, 32'h0001_2221, 0, "bp");
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      check("bp_out_data", {24'h0, out_data}, 32'h22);
      check("bp_out_valid", {31'h0, out_valid}, 32'd1);
      check("bp_in_ready", {31'h0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done("bp");

    // Reset after two bytes discards the partial operand
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mul_a", {16'h0, mul_a}, 32'd0);
    check("midrst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    load(16'h0003, 16'h0005, 32'h0000_000F, 0, "rst");
    wait_done("rst");

    // Gapped input; acc_clr high here is ignored or clear-then-add
    acc_clr = 1'b1;
    load(16'h0102, 16'h0304, 32'h0003_0A08, 2, "gap");
    wait_done("gap");
    acc_clr = ACC;

`ifdef VEDIC_ACC_EN
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    load(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, "acc1");
    wait_done("acc1");
    load(16'hFFFF, 16'hFFFF, 32'hFFFC_0002, 0, "acc2");
    wait_done("acc2");
    acc_clr = 1'b1;
    load(16'h0002, 16'h0003, 32'h0000_0006, 0, "acc3");
    wait_done("acc3");
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
